// File: rtl/phy_tx_arbiter.sv
// phy_tx_arbiter: frame-level round-robin share of the PHY transmit port between two requesters.
// Define ARB_TIMEOUT_EN to release a grant stalled mid-frame for TIMEOUT cycles.
module phy_tx_arbiter #(
    parameter logic [31:0] IDLE_SYM = 32'h7C7C7C7C,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic [31:0] data_in,
    output logic        valid_in,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t      state, state_n;
    logic        rr, rr_n;
    logic        cur_valid, cur_last, decide, v0, v1, pick0, pick1, tmo;
    logic [31:0] cur_data;

    assign req0_ready = state == GNT0;
    assign req1_ready = state == GNT1;
    assign grant      = {req1_ready, req0_ready};

    // The owner's valid during its last beat belongs to the frame just ending, so only the other side competes.
    always_comb begin
        cur_valid = req0_ready ? req0_valid : req1_ready && req1_valid;
        cur_last  = req0_ready ? req0_last : req1_last;
        cur_data  = req0_ready ? req0_data : req1_data;
        v0        = req0_valid && !req0_ready;
        v1        = req1_valid && !req1_ready;
        pick0     = v0 && (!v1 || !rr);
        pick1     = v1 && (!v0 || rr);
        decide    = state == IDLE || (cur_valid && cur_last) || tmo;
        state_n   = !decide ? state : pick0 ? GNT0 : pick1 ? GNT1 : IDLE;
        rr_n      = !decide ? rr : pick0 ? 1'b1 : pick1 ? 1'b0 : rr;
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state    <= IDLE;
            rr       <= 1'b0;
            data_in  <= IDLE_SYM;
            valid_in <= 1'b0;
        end else begin
            state    <= state_n;
            rr       <= rr_n;
            data_in  <= cur_valid ? cur_data : IDLE_SYM;
            valid_in <= cur_valid;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       stall;

    assign stall = state != IDLE && !cur_valid;
    assign tmo   = stall && stall_cnt == 8'(TIMEOUT - 1);

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            stall_cnt   <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            stall_cnt   <= (tmo || !stall) ? 8'd0 : stall_cnt + 8'd1;
            timeout_err <= tmo;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_phy_tx_arbiter.sv
// tb_phy_tx_arbiter: scoreboard bench for phy_tx_arbiter, directed frames with hand-computed output cycles.
module tb_phy_tx_arbiter;
    localparam logic [31:0] IDLE = 32'h7C7C7C7C;

    logic        clk_2f = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic        req0_ready, req1_ready, valid_in, timeout_err;
    logic [31:0] data_in;
    logic [1:0]  grant;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;

    phy_tx_arbiter #(.IDLE_SYM(IDLE), .TIMEOUT(4)) dut (
        .clk_2f(clk_2f), .reset(reset),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
        .data_in(data_in), .valid_in(valid_in), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk_2f = ~clk_2f;
    always @(posedge clk_2f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic expect_word(input logic [31:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    always @(negedge clk_2f) begin
        if (mon_en) begin
            if (valid_in) begin
                if (sb.size() == 0) check("unexpected_word", data_in, IDLE);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_data", data_in, e.d);
                    check("word_cycle", cyc, e.c);
                end
            end else check("idle_sym", data_in, IDLE);
        end
    end

    task automatic put(input int p, input logic v, input logic [31:0] d, input logic l);
        if (p == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    task automatic drv(input int p, input logic [31:0] w0, w1, w2, w3, input int n,
                       input bit term, input int gap_at, input int gap_len);
        logic [31:0] w[4];
        int          k;
        bit          r;
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                put(p, 1'b0, w[i], 1'b0);
                repeat (gap_len) @(posedge clk_2f);
                #1;
            end
            put(p, 1'b1, w[i], term && i == n - 1);
            k = 0;
            r = 1'b0;
            while (!r && k < 200) begin
                @(negedge clk_2f);
                r = (p == 0) ? req0_ready : req1_ready;
                @(posedge clk_2f);
                #1;
                k++;
            end
            check("accepted", 32'(r), 32'd1);
        end
        put(p, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        put(0, 1'b1, 32'hDEAD0000, 1'b0);
        put(1, 1'b1, 32'hDEAD0001, 1'b1);
        repeat (2) begin
            @(posedge clk_2f);
            @(negedge clk_2f);
            check("rst_valid", 32'(valid_in), 32'd0);
            check("rst_data", data_in, IDLE);
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
            check("rst_tmo", 32'(timeout_err), 32'd0);
        end
        @(posedge clk_2f);
        #1;
        reset = 1'b0;
        put(0, 1'b0, '0, 1'b0);
        put(1, 1'b0, '0, 1'b0);
        mon_en = 1'b1;
    endtask

    initial begin
        int s;
        do_reset();

        s = cyc;
        expect_word(32'hA0, s + 2); expect_word(32'hA1, s + 3); expect_word(32'hA2, s + 4);
        fork
            drv(0, 32'hA0, 32'hA1, 32'hA2, 0, 3, 1'b1, -1, 0);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk_2f);
                check("single_grant", 32'(grant), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
            end
        join
        repeat (2) @(posedge clk_2f);
        #1;

        do_reset();
        s = cyc;
        expect_word(32'hB0, s + 2); expect_word(32'hB1, s + 3);
        expect_word(32'hC0, s + 4); expect_word(32'hC1, s + 5);
        fork
            drv(0, 32'hB0, 32'hB1, 0, 0, 2, 1'b1, -1, 0);
            drv(1, 32'hC0, 32'hC1, 0, 0, 2, 1'b1, -1, 0);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk_2f);
                check("contend_grant", 32'(grant), (i == 0 || i == 5) ? 32'd0 : (i <= 2) ? 32'd1 : 32'd2);
            end
        join
        @(posedge clk_2f);
        #1;

        s = cyc;
        expect_word(32'hD0, s + 2); expect_word(32'hD1, s + 3);
        expect_word(32'hD2, s + 7); expect_word(32'hD3, s + 8);
        expect_word(32'hE0, s + 9); expect_word(32'hE1, s + 10);
        fork
            drv(1, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 4, 1'b1, 2, 3);
            begin
                @(posedge clk_2f);
                #1;
                drv(0, 32'hE0, 32'hE1, 0, 0, 2, 1'b1, -1, 0);
            end
            for (int i = 0; i < 11; i++) begin
                @(negedge clk_2f);
                check("bubble_grant", 32'(grant), (i == 0 || i == 10) ? 32'd0 : (i <= 7) ? 32'd2 : 32'd1);
            end
        join
        @(posedge clk_2f);
        #1;

        s = cyc;
        expect_word(32'hF0, s + 2);
`ifdef ARB_TIMEOUT_EN
        expect_word(32'h60, s + 7); expect_word(32'h61, s + 8);
        fork
            drv(0, 32'hF0, 0, 0, 0, 1, 1'b0, -1, 0);
            begin
                @(posedge clk_2f);
                #1;
                drv(1, 32'h60, 32'h61, 0, 0, 2, 1'b1, -1, 0);
            end
            for (int i = 0; i < 9; i++) begin
                @(negedge clk_2f);
                check("tmo_grant", 32'(grant), (i == 0 || i == 8) ? 32'd0 : (i <= 5) ? 32'd1 : 32'd2);
                check("tmo_pulse", 32'(timeout_err), 32'(i == 6));
            end
        join
`else
        fork
            drv(0, 32'hF0, 0, 0, 0, 1, 1'b0, -1, 0);
            begin
                @(posedge clk_2f);
                #1;
                put(1, 1'b1, 32'h60, 1'b0);
            end
            for (int i = 0; i < 51; i++) begin
                @(negedge clk_2f);
                check("hold_grant", 32'(grant), (i == 0) ? 32'd0 : 32'd1);
                check("hold_tmo", 32'(timeout_err), 32'd0);
            end
        join
`endif
        @(posedge clk_2f);
        #1;
        do_reset();
        repeat (3) @(posedge clk_2f);
        @(negedge clk_2f);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end
endmodule
